// File: rtl/hack_pkg.sv
// Shared types, widths and the 8-way load decode used by the memory blocks.
package hack_pkg;

    localparam int WORD_W       = 16;
    localparam int RAM8_ADDR_W  = 3;
    localparam int RAM64_ADDR_W = 6;

    typedef logic [WORD_W-1:0] word_t;

    // One-hot load decode: sel 000 drives bit 7, sel 111 drives bit 0.
    // All outputs stay low when the input is low.
    function automatic logic [7:0] dmux8way(input logic in, input logic [2:0] sel);
        logic [7:0] out;
        out = 8'h00;
        if (in) begin
            out = 8'h80 >> sel;
        end
        return out;
    endfunction

endpackage

// File: rtl/ram8.sv
// Eight-word register bank with a one-hot load decode and a combinational read select.
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       i,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       o
);

    logic [7:0]       word_load;
    logic [WIDTH-1:0] word_q [8];

    // Only the addressed word sees a load; the others hold.
    assign word_load = dmux8way(load, address);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;

            // Word register: cleared by reset, loaded when its decode bit is set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (word_load[7-gi]) begin
                    word_reg <= i;
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    // Read select is purely combinational: no bypass of i, no output register.
    assign o = word_q[address];

endmodule

// File: rtl/ram64.sv
// 64-word RAM built from eight ram8 banks; address[5:3] picks the bank.
module ram64
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        i,
    input  logic                    load,
    input  logic [RAM64_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]        o
);

    logic [2:0]       bank_sel;
    logic [2:0]       word_sel;
    logic [7:0]       bank_load;
    logic [WIDTH-1:0] bank_o [8];

    assign bank_sel = address[5:3];
    assign word_sel = address[2:0];

    // At most one bank load is high, and none when load is low.
    assign bank_load = dmux8way(load, bank_sel);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bank
            ram8 #(
                .WIDTH(WIDTH)
            ) u_ram8 (
                .clk    (clk),
                .rst_n  (rst_n),
                .i      (i),
                .load   (bank_load[7-gi]),
                .address(word_sel),
                .o      (bank_o[gi])
            );
        end
    endgenerate

    // Bank read select follows the address with no clock involvement.
    assign o = bank_o[bank_sel];

endmodule

// File: doc/ram64.md
Name: ram64

Overview:
- 64-word × 16-bit RAM. It is the memory stage directly downstream of the DMux8Way decoders and directly upstream of the Mux8Way16 read selectors.
- Built hierarchically from eight ram8 banks:
  - address[5:3] selects the bank, through a DMux8Way-style load decode and a Mux8Way16-style read select.
  - address[2:0] selects the word within the bank.
- It is the building block for the larger RAM512/RAM4K/RAM16K stack.

Parameters:
- WIDTH, 16, data word width in bits. All instances in the design use 16.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset. Clears every stored word.
- i, input, WIDTH, write data.
- load, input, 1, write enable, sampled on the rising edge of clk.
- address, input, 6, word address. [5:3] is the bank, [2:0] is the word within the bank.
- o, output, WIDTH, read data: contents of the word at address.

Behaviour:
- Storage: 64 registers of WIDTH bits (8 banks × 8 words).
- Reset:
  - When rst_n goes low, all 64 words clear to 0 immediately, without waiting for a clock edge.
  - o therefore reads 0 for every address while rst_n is low and after release, until a write occurs.
  - Reset overrides load. No write takes effect on any edge where rst_n is low.
  - rst_n release is asserted synchronously to clk by the system. The first write can occur on the first rising edge with rst_n high.
- Write:
  - On the rising clk edge with rst_n=1 and load=1, RAM[address] takes the value of i.
  - Exactly one word is written. All 63 other words hold.
  - Write latency is 1 cycle.
- Hold: load=0 means all words hold their value indefinitely.
- Read:
  - o = RAM[address], combinational from address and the stored contents, with 0-cycle latency. There is no output register.
  - A change of address with no clock edge updates o within the same cycle.
- Read-during-write to the same address:
  - Before the edge, o shows the old value.
  - After the edge, o shows i.
  - There is no write-through bypass of i to o.
- Bank decode:
  - Exactly one bank's load is asserted (bank = address[5:3]), and only when load=1.
  - All other bank loads are 0.
  - When load=0, all eight bank loads are 0.
- Address wrap: not applicable. All 64 values of the 6-bit address are valid.
- X handling: address or load containing X/Z is illegal input. Behaviour is unspecified, and the bench must not drive it after reset.
- Reset mid-operation: asserting rst_n during a cycle with load=1 discards that write. Contents are 0 after the reset.

Decomposition:
- Package hack_pkg:
  - typedef word_t as logic [15:0].
  - Constants: WORD_W=16, RAM8_ADDR_W=3, RAM64_ADDR_W=6.
  - Shared by the mux, dmux and memory blocks.
- Sub-module ram8:
  - Ports: clk, rst_n, i, load, address[2:0], o.
  - Holds 8 word registers.
  - Uses an 8-way load decode (same one-hot mapping as DMux8Way: sel 000 → bit 7 … 111 → bit 0) and an 8-way read select (Mux8Way16).
- ram64 instantiates:
  - eight ram8 banks,
  - one 8-way load decode on address[5:3],
  - one 8-way read select on address[5:3].

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 cycles, then release. Sweep address 0..63 with load=0.
   - Required response: o==0 for every address.
2. Write/read sweep:
   - Stimulus: for a in 0..63, write i=a+1 at address a with load=1, one edge each. Then set load=0 and read back all 64 addresses.
   - Required response: o==a+1 at every address. Confirms no aliasing between banks or words.
3. Hold with load=0:
   - Stimulus: after scenario 2, drive i=16'hFFFF, load=0, address=5 for 10 edges.
   - Required response: o==6 throughout. Address 13 still reads 14.
4. Read-during-write timing:
   - Stimulus: address=9 holding 10; drive i=16'hBEEF, load=1.
   - Required response: o==10 before the edge and 16'hBEEF after it. Address 17 (same word index, different bank) is unchanged at 18.
5. Bank boundary:
   - Stimulus: write 16'h1234 to address 7, then 16'h5678 to address 8.
   - Required response: address 7 reads 16'h1234 and address 8 reads 16'h5678. Addresses 6 and 15 keep their prior values.
6. Async reset mid-write:
   - Stimulus: load=1, address=63, i=16'hAAAA; pull rst_n low mid-cycle, before the edge.
   - Required response: o drops to 0 without a clock edge. After release, address 63 reads 0, not 16'hAAAA.
